// File: rtl/addr4_reduce_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : addr4_reduce_ctrl_pkg
// Description : Shared state encoding, slot geometry and sizing helper for
//               the four-at-a-time vector reduction controller.
// Revision    : 1.0 - initial release
// ============================================================================
package addr4_reduce_ctrl_pkg;

    // State encoding, 2 bits wide
    localparam logic [1:0] c_ST_GATHER = 2'd0;
    localparam logic [1:0] c_ST_ADD    = 2'd1;
    localparam logic [1:0] c_ST_ACC    = 2'd2;
    localparam logic [1:0] c_ST_DONE   = 2'd3;

    typedef enum logic [1:0] {
        GATHER = c_ST_GATHER,
        ADD    = c_ST_ADD,
        ACC    = c_ST_ACC,
        DONE   = c_ST_DONE
    } state_t;

    // Slot geometry of the shared adder
    localparam int         c_NUM_SLOTS = 4;
    localparam int         c_SLOT_W    = 2;
    localparam logic [1:0] c_SLOT_LAST = 2'd3;

    // Ceiling log2, never smaller than 1 so counters always have a bit
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage : addr4_reduce_ctrl_pkg
`default_nettype wire

// File: rtl/addr4.sv
`default_nettype none
// ============================================================================
// Module      : addr4
// Description : Registered 4-input signed adder. The output is two bits wider
//               than the inputs, so the sum never overflows.
// Revision    : 1.0 - initial release
// ============================================================================
module addr4 #(
    parameter int IN_WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [IN_WIDTH-1:0] i_a,
    input  logic [IN_WIDTH-1:0] i_b,
    input  logic [IN_WIDTH-1:0] i_c,
    input  logic [IN_WIDTH-1:0] i_d,
    output logic [IN_WIDTH+1:0] o_sum
);

    localparam int c_SUM_W = IN_WIDTH + 2;

    logic [c_SUM_W-1:0] w_a_ext;
    logic [c_SUM_W-1:0] w_b_ext;
    logic [c_SUM_W-1:0] w_c_ext;
    logic [c_SUM_W-1:0] w_d_ext;
    logic [c_SUM_W-1:0] w_sum;
    logic [c_SUM_W-1:0] r_sum;

    // Sign-extend every operand to the full sum width and add them
    always_comb begin
        w_a_ext = {{2{i_a[IN_WIDTH-1]}}, i_a};
        w_b_ext = {{2{i_b[IN_WIDTH-1]}}, i_b};
        w_c_ext = {{2{i_c[IN_WIDTH-1]}}, i_c};
        w_d_ext = {{2{i_d[IN_WIDTH-1]}}, i_d};
        w_sum   = w_a_ext + w_b_ext + w_c_ext + w_d_ext;
    end

    // Output register, cleared by the active-high synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum <= '0;
        end else begin
            r_sum <= w_sum;
        end
    end

    assign o_sum = r_sum;

endmodule : addr4
`default_nettype wire

// File: rtl/addr4_reduce_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : addr4_reduce_ctrl
// Description : Reduces a vector of NUM_IN signed words into one sum by
//               gathering four words at a time, pushing them through a shared
//               registered 4-input adder and accumulating the partial sums.
//               Valid/ready on both the input and the result side.
// Revision    : 1.0 - initial release
// ============================================================================
module addr4_reduce_ctrl
    import addr4_reduce_ctrl_pkg::*;
#(
    parameter int IN_WIDTH  = 32,
    parameter int NUM_IN    = 16,
    parameter int OUT_WIDTH = 36
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_WIDTH-1:0]  d_i,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [OUT_WIDTH-1:0] d_o,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int               c_VEC_W    = clog2(NUM_IN + 1);
    localparam int               c_SUM_W    = IN_WIDTH + 2;
    localparam logic [c_VEC_W-1:0] c_VEC_FULL = c_VEC_W'(NUM_IN);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [IN_WIDTH-1:0]   r_slot [c_NUM_SLOTS];
    logic [c_SLOT_W-1:0]   r_slot_cnt;
    logic [c_VEC_W-1:0]    r_vec_cnt;
    logic [c_VEC_W-1:0]    w_vec_inc;
    logic [OUT_WIDTH-1:0]  r_acc;

    logic                  w_in_ready;
    logic                  w_out_valid;
    logic                  w_accept;
    logic                  w_out_hs;

    logic [IN_WIDTH-1:0]   w_add_a;
    logic [IN_WIDTH-1:0]   w_add_b;
    logic [IN_WIDTH-1:0]   w_add_c;
    logic [IN_WIDTH-1:0]   w_add_d;
    logic [c_SUM_W-1:0]    w_add_sum;
    logic [OUT_WIDTH-1:0]  w_add_ext;
    logic                  w_add_rst;

    // Handshake qualifiers; outputs are forced idle while reset is asserted
    assign in_ready  = w_in_ready & rst;
    assign out_valid = w_out_valid & rst;
    assign d_o       = out_valid ? r_acc : '0;
    assign w_accept  = in_valid & in_ready;
    assign w_out_hs  = out_valid & out_ready;
    assign w_vec_inc = r_vec_cnt + 1'b1;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= GATHER;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake output decode
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            GATHER: begin
                w_in_ready = 1'b1;
                // Launch the adder once four slots are filled or the vector ends
                if (in_valid && ((r_slot_cnt == c_SLOT_LAST) || (w_vec_inc == c_VEC_FULL))) begin
                    w_state_nxt = ADD;
                end
            end
            ADD: begin
                w_state_nxt = ACC;
            end
            ACC: begin
                w_state_nxt = (r_vec_cnt == c_VEC_FULL) ? DONE : GATHER;
            end
            DONE: begin
                w_out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = GATHER;
                end
            end
            default: begin
                w_state_nxt = GATHER;
            end
        endcase
    end

    // Slot capture during GATHER; slots empty out once the adder has sampled them
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < c_NUM_SLOTS; i++) begin
                r_slot[i] <= '0;
            end
            r_slot_cnt <= '0;
        end else if (r_state == ADD) begin
            for (int i = 0; i < c_NUM_SLOTS; i++) begin
                r_slot[i] <= '0;
            end
            r_slot_cnt <= '0;
        end else if (w_accept) begin
            r_slot[r_slot_cnt] <= d_i;
            r_slot_cnt         <= r_slot_cnt + 1'b1;
        end
    end

    // Words accepted so far in the current vector
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_vec_cnt <= '0;
        end else if (w_accept) begin
            r_vec_cnt <= w_vec_inc;
        end else if (w_out_hs) begin
            r_vec_cnt <= '0;
        end
    end

    // Adder operands come only from the slots and are zero outside ADD,
    // so unfilled slots of a short final group contribute nothing
    always_comb begin
        w_add_a = '0;
        w_add_b = '0;
        w_add_c = '0;
        w_add_d = '0;
        if (r_state == ADD) begin
            w_add_a = r_slot[0];
            w_add_b = r_slot[1];
            w_add_c = r_slot[2];
            w_add_d = r_slot[3];
        end
    end

    assign w_add_rst = ~rst;

    addr4 #(
        .IN_WIDTH (IN_WIDTH)
    ) u_addr4 (
        .clk   (clk),
        .rst   (w_add_rst),
        .i_a   (w_add_a),
        .i_b   (w_add_b),
        .i_c   (w_add_c),
        .i_d   (w_add_d),
        .o_sum (w_add_sum)
    );

    // Sign-extend (or wrap) the group sum to the accumulator width
    assign w_add_ext = OUT_WIDTH'($signed(w_add_sum));

    // Accumulate one group sum per ACC; the result clears once consumed
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_acc <= '0;
        end else if (r_state == ACC) begin
            r_acc <= r_acc + w_add_ext;
        end else if (w_out_hs) begin
            r_acc <= '0;
        end
    end

endmodule : addr4_reduce_ctrl
`default_nettype wire

// File: tb/tb_addr4_reduce_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_addr4_reduce_ctrl
// Description : Directed bench for addr4_reduce_ctrl: default 16-word
//               instance plus a 6-word instance for the short final group.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_addr4_reduce_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] d_i;
    logic        in_valid;
    logic        in_ready;
    logic [35:0] d_o;
    logic        out_valid;
    logic        out_ready;

    logic [31:0] d6_i;
    logic        in_valid6;
    logic        in_ready6;
    logic [34:0] d6_o;
    logic        out_valid6;
    logic        out_ready6;

    int checks = 0;
    int errors = 0;

    addr4_reduce_ctrl #(
        .IN_WIDTH  (32),
        .NUM_IN    (16),
        .OUT_WIDTH (36)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .d_i       (d_i),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .d_o       (d_o),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    addr4_reduce_ctrl #(
        .IN_WIDTH  (32),
        .NUM_IN    (6),
        .OUT_WIDTH (35)
    ) dut6 (
        .clk       (clk),
        .rst       (rst),
        .d_i       (d6_i),
        .in_valid  (in_valid6),
        .in_ready  (in_ready6),
        .d_o       (d6_o),
        .out_valid (out_valid6),
        .out_ready (out_ready6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Feed up to 16 words to the default instance and collect the result.
    // Called and returns at 1 time unit after a rising edge.
    task automatic run_vec(input logic [31:0] w [16], input bit bubbles, input bit timing,
                           input int hold, input int stop_at, input logic [35:0] exp,
                           input string tag);
        int          idx;
        int          cyc;
        bit          done;
        bit          acc_now;
        int          tmon;
        logic [2:0]  pat;
        bit          fin;
        int          grp;
        int          held;
        logic [35:0] cap;
        bit          stable_ok;
        idx = 0; cyc = 0; done = 0; tmon = 0; pat = '0; fin = 0; grp = 0;
        held = 0; cap = '0; stable_ok = 1;
        out_ready = 1'b1;
        while (!done && !(stop_at < 16 && idx == stop_at) && cyc < 400) begin
            if (tmon > 0) begin
                pat = {pat[1:0], fin ? out_valid : in_ready};
                if (tmon == 3) begin
                    if (timing) check($sformatf("%s timing grp%0d", tag, grp), 64'(pat), 64'(3'b001));
                    tmon = 0;
                end else begin
                    tmon++;
                end
            end
            if (out_valid) begin
                if (held < hold) begin
                    if (held == 0) cap = d_o;
                    else if (d_o !== cap) stable_ok = 0;
                    if (in_ready) stable_ok = 0;
                    out_ready = 1'b0;
                    held++;
                end else begin
                    if (hold > 0) begin
                        if (d_o !== cap || in_ready) stable_ok = 0;
                        check({tag, " hold stable"}, 64'(stable_ok), 64'(1));
                    end
                    out_ready = 1'b1;
                    check(tag, 64'(d_o), 64'(exp));
                    done = 1;
                end
            end else if (held > 0) begin
                stable_ok = 0;
            end
            if (idx < 16 && !(stop_at < 16 && idx >= stop_at)) begin
                in_valid = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
                d_i      = w[idx];
            end else begin
                in_valid = 1'b0;
                d_i      = '0;
            end
            acc_now = in_valid & in_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc_now) begin
                idx++;
                if (idx % 4 == 0 || idx == 16) begin
                    tmon = 1; pat = '0; fin = (idx == 16); grp = idx / 4;
                end
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        if (!done && stop_at >= 16) check({tag, " timeout"}, 64'(done), 64'(1));
    endtask

    // Feed a 6-word vector to the short-vector instance and check the result
    task automatic run6(input logic [31:0] w [6], input logic [34:0] exp, input string tag);
        int idx;
        int cyc;
        bit done;
        bit acc_now;
        idx = 0; cyc = 0; done = 0;
        out_ready6 = 1'b1;
        while (!done && cyc < 200) begin
            if (out_valid6) begin
                check(tag, 64'(d6_o), 64'(exp));
                done = 1;
            end
            if (idx < 6) begin
                in_valid6 = 1'b1;
                d6_i      = w[idx];
            end else begin
                in_valid6 = 1'b0;
                d6_i      = '0;
            end
            acc_now = in_valid6 & in_ready6;
            @(posedge clk); #1;
            cyc++;
            if (acc_now) idx++;
        end
        in_valid6 = 1'b0;
        if (!done) check({tag, " timeout"}, 64'(done), 64'(1));
    endtask

    logic [31:0] ramp   [16];
    logic [31:0] negs   [16];
    logic [31:0] mixed  [16];
    logic [31:0] hundreds6 [6];
    logic [31:0] ramp6  [6];

    initial begin
        for (int i = 0; i < 16; i++) begin
            ramp[i]  = 32'(i + 1);
            negs[i]  = 32'hFFFF_FFFF;
            mixed[i] = (i % 2 == 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        end
        for (int i = 0; i < 6; i++) begin
            hundreds6[i] = 32'd100;
            ramp6[i]     = 32'(i + 1);
        end

        rst        = 1'b0;
        d_i        = '0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        d6_i       = '0;
        in_valid6  = 1'b0;
        out_ready6 = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready",  64'(in_ready),  64'(0));
        check("reset out_valid", 64'(out_valid), 64'(0));
        check("reset d_o",       64'(d_o),       64'(0));
        rst = 1'b1;
        #1;
        check("release in_ready", 64'(in_ready), 64'(1));
        @(posedge clk); #1;

        // Sum 1..16 with group timing
        run_vec(ramp, 1'b0, 1'b1, 0, 16, 36'd136, "sum 1..16");

        // Negative values
        run_vec(negs,  1'b0, 1'b0, 0, 16, 36'hFFFFFFFF0, "all -1");
        run_vec(mixed, 1'b0, 1'b0, 0, 16, 36'hFFFFFFFF8, "max/min mix");

        // Short final group on the 6-word instance, preceded by 100s
        run6(hundreds6, 35'd600, "n6 hundreds");
        run6(ramp6,     35'd21,  "n6 sum 1..6");

        // Output backpressure, then a follow-on vector
        run_vec(negs, 1'b0, 1'b0, 5, 16, 36'hFFFFFFFF0, "backpressure");
        run_vec(ramp, 1'b0, 1'b0, 0, 16, 36'd136, "after backpressure");

        // Reset after 7 accepts
        run_vec(ramp, 1'b0, 1'b0, 0, 7, 36'd0, "partial");
        rst = 1'b0;
        #1;
        check("midreset in_ready",  64'(in_ready),  64'(0));
        check("midreset out_valid", 64'(out_valid), 64'(0));
        check("midreset d_o",       64'(d_o),       64'(0));
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("midreset release in_ready", 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        run_vec(ramp, 1'b0, 1'b0, 0, 16, 36'd136, "after midreset");

        // Input bubbles
        run_vec(ramp, 1'b1, 1'b0, 0, 16, 36'd136, "bubbles");

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_addr4_reduce_ctrl
`default_nettype wire
